// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
package tour_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_SNT, ST_WAIT_RESP, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_ACK = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_PROTO   = 2'd3
    } err_code_t;

    localparam logic [7:0]  POS_ACK_DEF  = 8'hA5;

    // Knight opcodes live in the top nibble of the 16-bit command word
    localparam logic [3:0]  OP_CAL_GYRO  = 4'h2;
    localparam logic [3:0]  OP_MOVE      = 4'h4;
    localparam logic [3:0]  OP_MOVE_FAN  = 4'h5;
    localparam logic [3:0]  OP_TOUR      = 4'h6;
    localparam logic [15:0] CMD_CAL_GYRO = {OP_CAL_GYRO, 12'h000};

    function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [11:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/tour_cmd_ram.sv
// DEPTH x 16 command slot storage: one synchronous write port, one async read port.
module tour_cmd_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Plays a programmed list of Knight commands into RemoteComm, checking each ack.
// Define TOUR_SEQ_RETRY_EN to re-send a failing entry once before aborting.
module tour_cmd_sequencer
    import tour_seq_pkg::*;
#(
    parameter int         DEPTH        = 16,
    parameter int         TIMEOUT_CLKS = 5_000_000,
    parameter logic [7:0] POS_ACK      = POS_ACK_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [15:0]              load_data_i,
    input  logic [$clog2(DEPTH):0]   num_cmds_i,
    input  logic                     start_i,
    output logic [15:0]              cmd_o,
    output logic                     snd_cmd_o,
    input  logic                     cmd_snt_i,
    input  logic                     resp_rdy_i,
    input  logic [7:0]               resp_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    output logic [$clog2(DEPTH)-1:0] cmd_idx_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, last_q, last_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          done_q, done_d, err_q, err_d;
    err_code_t     code_q, code_d;
    logic          fail;
    err_code_t     fail_code;
    logic          ack, tmo;
    logic [AW:0]   n_eff, n_m1;
    logic [15:0]   rd_data;
`ifdef TOUR_SEQ_RETRY_EN
    logic          retry_q, retry_d;
`endif

    assign busy_o = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});

    tour_cmd_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (load_we_i && !busy_o),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    assign n_eff = (num_cmds_i > DEPTH_W) ? DEPTH_W : num_cmds_i;
    assign n_m1  = n_eff - 1'b1;
    assign ack   = (resp_i == POS_ACK);
    assign tmo   = (tmr_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cmd_d     = cmd_q;
        tmr_d     = tmr_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        fail      = 1'b0;
        fail_code = ERR_NONE;
`ifdef TOUR_SEQ_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    idx_d  = '0;
                    last_d = n_m1[AW-1:0];
`ifdef TOUR_SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                    if (n_eff == '0) done_d  = 1'b1;
                    else             state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cmd_d   = rd_data;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tmr_d   = '0;
                state_d = ST_WAIT_SNT;
            end
            ST_WAIT_SNT: begin
                tmr_d = tmr_q + 1'b1;
                // cmd_snt and resp_rdy together: the send completed, judge the response now
                if (cmd_snt_i && resp_rdy_i) begin
                    if (ack) state_d = ST_NEXT;
                    else begin fail = 1'b1; fail_code = ERR_BAD_ACK; end
                end else if (cmd_snt_i) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT_RESP;
                end else if (resp_rdy_i) begin
                    err_d   = 1'b1;
                    code_d  = ERR_PROTO;
                    state_d = ST_ERR;
                end else if (tmo) begin
                    fail = 1'b1; fail_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_RESP: begin
                tmr_d = tmr_q + 1'b1;
                if (resp_rdy_i) begin
                    if (ack) state_d = ST_NEXT;
                    else begin fail = 1'b1; fail_code = ERR_BAD_ACK; end
                end else if (tmo) begin
                    fail = 1'b1; fail_code = ERR_TIMEOUT;
                end
            end
            ST_NEXT: begin
`ifdef TOUR_SEQ_RETRY_EN
                retry_d = 1'b0;
`endif
                if (idx_q == last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef TOUR_SEQ_RETRY_EN
        if (fail && !retry_q) begin
            retry_d = 1'b1;
            state_d = ST_SEND;
        end else
`endif
        if (fail) begin
            err_d   = 1'b1;
            code_d  = fail_code;
            state_d = ST_ERR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cmd_q   <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef TOUR_SEQ_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
`ifdef TOUR_SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign cmd_o      = cmd_q;
    assign snd_cmd_o  = (state_q == ST_SEND);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign cmd_idx_o  = idx_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Scoreboarded bench for tour_cmd_sequencer: expected commands are queued at start and popped on snd_cmd.
module tb_tour_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 100;

    logic          clk = 1'b0, rst = 1'b1;
    logic          load_we = 1'b0, start = 1'b0, cmd_snt = 1'b0, resp_rdy = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic [AW:0]   num_cmds = '0;
    logic [7:0]    resp = '0;
    logic [15:0]   cmd;
    logic          snd_cmd, busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] cmd_idx;

    int n_chk = 0, n_pass = 0, n_snd = 0, base;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    tour_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .POS_ACK(8'hA5)) dut (
        .clk_i(clk), .rst_i(rst), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_data_i(load_data), .num_cmds_i(num_cmds), .start_i(start),
        .cmd_o(cmd), .snd_cmd_o(snd_cmd), .cmd_snt_i(cmd_snt), .resp_rdy_i(resp_rdy),
        .resp_i(resp), .busy_o(busy), .done_o(done), .err_o(err),
        .err_code_o(err_code), .cmd_idx_o(cmd_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // scoreboard: every snd_cmd strobe must match the next queued command
    always @(negedge clk) begin
        logic [15:0] e;
        if (snd_cmd === 1'b1) begin
            n_snd++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 16'hxxxx;
            chk("sb_cmd", {16'h0, cmd}, {16'h0, e});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic go(input logic [AW:0] n);
        tick();
        num_cmds = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_snd();
        for (int i = 0; i < 50 && snd_cmd !== 1'b1; i++) tick();
        chk("snd_seen", {31'h0, snd_cmd}, 32'h1);
    endtask

    // RemoteComm model: finish sending one clk into WAIT_SNT, then return one response byte
    task automatic respond(input logic [7:0] r);
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0; resp_rdy = 1'b1; resp = r;
        tick();
        resp_rdy = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_snd",  {31'h0, snd_cmd}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err",  {31'h0, err}, 0);
        chk("rst_code", {30'h0, err_code}, 0);
        chk("rst_idx",  {28'h0, cmd_idx}, 0);
        chk("rst_cmd",  {16'h0, cmd}, 0);
        rst = 1'b0;
        load(0, 16'h2000);
        load(1, 16'h4BF1);

        // two-entry tour, both acked; a load attempt while busy must be dropped
        base = n_snd;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1);
        go(2);
        chk("run_busy", {31'h0, busy}, 1);
        load(1, 16'hFFFF);
        wait_snd(); respond(8'hA5);
        wait_snd(); respond(8'hA5);
        tick();
        chk("ok_done", {31'h0, done}, 1);
        chk("ok_err",  {31'h0, err}, 0);
        chk("ok_busy", {31'h0, busy}, 0);
        chk("ok_idx",  {28'h0, cmd_idx}, 1);
        chk("ok_nsnd", n_snd - base, 2);

`ifdef TOUR_SEQ_RETRY_EN
        // one bad ack is retried with the same command
        base = n_snd;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h2000);
        go(1);
        wait_snd(); respond(8'h5A);
        wait_snd(); respond(8'hA5);
        tick();
        chk("rty_done", {31'h0, done}, 1);
        chk("rty_nsnd", n_snd - base, 2);
        // two bad acks abort
        exp_q.push_back(16'h2000); exp_q.push_back(16'h2000);
        go(1);
        wait_snd(); respond(8'h5A);
        wait_snd(); respond(8'h5A);
        chk("rty2_err",  {31'h0, err}, 1);
        chk("rty2_code", {30'h0, err_code}, 1);
`else
        // second entry gets a bad ack
        base = n_snd;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1);
        go(2);
        wait_snd(); respond(8'hA5);
        wait_snd(); respond(8'h5A);
        chk("bad_err",  {31'h0, err}, 1);
        chk("bad_code", {30'h0, err_code}, 1);
        chk("bad_idx",  {28'h0, cmd_idx}, 1);
        chk("bad_busy", {31'h0, busy}, 0);
        chk("bad_done", {31'h0, done}, 0);
        repeat (10) tick();
        chk("bad_nsnd", n_snd - base, 2);

        // cmd_snt withheld: abort exactly TMO clks after entering WAIT_SNT
        exp_q.push_back(16'h2000);
        go(1);
        wait_snd();
        tick();
        repeat (TMO - 1) tick();
        chk("tmo_early", {31'h0, err}, 0);
        tick();
        chk("tmo_err",  {31'h0, err}, 1);
        chk("tmo_code", {30'h0, err_code}, 2);
        chk("tmo_busy", {31'h0, busy}, 0);
`endif

        // resp_rdy before cmd_snt is a protocol error
        exp_q.push_back(16'h2000);
        go(1);
        wait_snd();
        tick();
        resp_rdy = 1'b1; resp = 8'hA5;
        tick();
        resp_rdy = 1'b0;
        chk("pro_err",  {31'h0, err}, 1);
        chk("pro_code", {30'h0, err_code}, 3);
        chk("pro_idx",  {28'h0, cmd_idx}, 0);

        // empty list completes immediately with no send
        base = n_snd;
        go(0);
        chk("zero_done", {31'h0, done}, 1);
        chk("zero_err",  {31'h0, err}, 0);
        chk("zero_code", {30'h0, err_code}, 0);
        repeat (5) tick();
        chk("zero_nsnd", n_snd - base, 0);

        // reset during WAIT_RESP, then replay from slot 0
        exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1);
        go(2);
        wait_snd();
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        chk("mid_busy", {31'h0, busy}, 1);
        #1 rst = 1'b1;
        #1;
        chk("mrst_busy", {31'h0, busy}, 0);
        chk("mrst_snd",  {31'h0, snd_cmd}, 0);
        chk("mrst_done", {31'h0, done}, 0);
        chk("mrst_err",  {31'h0, err}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        base = n_snd;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h4BF1);
        go(2);
        wait_snd(); respond(8'hA5);
        wait_snd(); respond(8'hA5);
        tick();
        chk("rep_done", {31'h0, done}, 1);
        chk("rep_nsnd", n_snd - base, 2);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
